// File: rtl/laser_feeder.sv
// Host-side initiator for the LASER circle-placement core: stores a 40-point pattern,
// streams it to the core, waits for DONE and scores the returned centre pair.
module laser_feeder #(
  parameter int NPTS   = 40,
  parameter int TO_W   = 16,
  parameter int TO_MAX = 40000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       WE,
  input  logic [5:0] WADDR,
  input  logic [7:0] WDATA,
  input  logic       START,
  output logic       BUSY,
  output logic       CORE_RST,
  output logic [3:0] X,
  output logic [3:0] Y,
  input  logic       DONE,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  output logic [3:0] R_C1X,
  output logic [3:0] R_C1Y,
  output logic [3:0] R_C2X,
  output logic [3:0] R_C2Y,
  output logic [5:0] SCORE,
  output logic       RES_VALID,
  output logic       TO_ERR
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CRST   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_SCORE  = 3'd4;
  localparam logic [2:0] S_REPORT = 3'd5;

  localparam logic [5:0]      L_LAST = 6'(NPTS - 1);
  localparam logic [TO_W-1:0] L_TO   = TO_W'(TO_MAX - 1);

  logic [2:0]      r_state;
  logic [5:0]      r_idx;
  logic [TO_W-1:0] r_tcnt;
  logic [7:0]      r_mem [NPTS];
  logic [3:0]      r_c1x, r_c1y, r_c2x, r_c2y;
  logic [5:0]      r_score;
  logic            r_to_err;

  logic [7:0]      w_pt;
  logic            w_in1;
  logic            w_in2;

  function automatic logic in_circle(input logic [3:0] px, input logic [3:0] py,
                                     input logic [3:0] cx, input logic [3:0] cy);
    logic [3:0] dx;
    logic [3:0] dy;
    logic [8:0] d2;
    dx = (px >= cx) ? px - cx : cx - px;
    dy = (py >= cy) ? py - cy : cy - py;
    d2 = {5'd0, dx} * {5'd0, dx} + {5'd0, dy} * {5'd0, dy};
    return d2 <= 9'd16;
  endfunction

  // Combinational read so point k is on the bus in the same cycle the index reaches k.
  assign w_pt  = r_mem[r_idx];
  assign w_in1 = in_circle(w_pt[3:0], w_pt[7:4], r_c1x, r_c1y);
  assign w_in2 = in_circle(w_pt[3:0], w_pt[7:4], r_c2x, r_c2y);

  always_ff @(posedge CLK) begin
    if (WE && (r_state == S_IDLE) && (WADDR <= L_LAST)) begin
      r_mem[WADDR] <= WDATA;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_idx    <= 6'd0;
      r_tcnt   <= '0;
      r_c1x    <= 4'd0;
      r_c1y    <= 4'd0;
      r_c2x    <= 4'd0;
      r_c2y    <= 4'd0;
      r_score  <= 6'd0;
      r_to_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_state  <= S_CRST;
            r_idx    <= 6'd0;
            r_to_err <= 1'b0;
            r_score  <= 6'd0;
            r_c1x    <= 4'd0;
            r_c1y    <= 4'd0;
            r_c2x    <= 4'd0;
            r_c2y    <= 4'd0;
          end
        end
        S_CRST: begin
          r_state <= S_STREAM;
          r_idx   <= 6'd0;
        end
        S_STREAM: begin
          if (r_idx == L_LAST) begin
            r_state <= S_WAIT;
            r_idx   <= 6'd0;
            r_tcnt  <= '0;
          end else begin
            r_idx <= r_idx + 6'd1;
          end
        end
        S_WAIT: begin
          // DONE wins over a timeout landing in the same cycle.
          if (DONE) begin
            r_c1x   <= C1X;
            r_c1y   <= C1Y;
            r_c2x   <= C2X;
            r_c2y   <= C2Y;
            r_idx   <= 6'd0;
            r_state <= S_SCORE;
          end else if (r_tcnt == L_TO) begin
            r_to_err <= 1'b1;
            r_score  <= 6'd0;
            r_state  <= S_REPORT;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_SCORE: begin
          if (w_in1 || w_in2) begin
            r_score <= r_score + 6'd1;
          end
          if (r_idx == L_LAST) begin
            r_state <= S_REPORT;
          end else begin
            r_idx <= r_idx + 6'd1;
          end
        end
        S_REPORT: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // The core is held in reset whenever this block is, not only during the CRST cycle.
  assign CORE_RST  = ~RST_N | (r_state == S_CRST);
  assign BUSY      = (r_state != S_IDLE);
  assign X         = (r_state == S_STREAM) ? w_pt[3:0] : 4'd0;
  assign Y         = (r_state == S_STREAM) ? w_pt[7:4] : 4'd0;
  assign RES_VALID = (r_state == S_REPORT);
  assign SCORE     = r_score;
  assign TO_ERR    = r_to_err;
  assign R_C1X     = r_c1x;
  assign R_C1Y     = r_c1y;
  assign R_C2X     = r_c2x;
  assign R_C2Y     = r_c2y;

endmodule

// File: tb/tb_laser_feeder.sv
// Directed bench for laser_feeder: acts as host and as a scripted core model.
module tb_laser_feeder;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       WE = 1'b0;
  logic [5:0] WADDR = 6'd0;
  logic [7:0] WDATA = 8'd0;
  logic       START = 1'b0;
  logic       DONE = 1'b0;
  logic [3:0] C1X = 4'd0, C1Y = 4'd0, C2X = 4'd0, C2Y = 4'd0;
  logic       BUSY, CORE_RST, RES_VALID, TO_ERR;
  logic [3:0] X, Y, R_C1X, R_C1Y, R_C2X, R_C2Y;
  logic [5:0] SCORE;

  logic [7:0] exp_mem [40];
  int n_checks = 0;
  int n_fail = 0;

  laser_feeder #(.NPTS(40), .TO_W(16), .TO_MAX(100)) dut (
    .CLK(CLK), .RST_N(RST_N), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .START(START), .BUSY(BUSY), .CORE_RST(CORE_RST), .X(X), .Y(Y),
    .DONE(DONE), .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
    .R_C1X(R_C1X), .R_C1Y(R_C1Y), .R_C2X(R_C2X), .R_C2Y(R_C2Y),
    .SCORE(SCORE), .RES_VALID(RES_VALID), .TO_ERR(TO_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic write_pt(input logic [5:0] addr, input logic [3:0] px, input logic [3:0] py);
    @(negedge CLK);
    WE = 1'b1; WADDR = addr; WDATA = {py, px};
    if (addr < 6'd40) exp_mem[addr] = {py, px};
    @(negedge CLK);
    WE = 1'b0;
  endtask

  // One full transaction. give_done=0 models a core that never answers.
  task automatic run(input logic [3:0] c1x, input logic [3:0] c1y,
                     input logic [3:0] c2x, input logic [3:0] c2y,
                     input logic give_done, input int exp_score, input logic inject,
                     input logic wr_start, input logic [5:0] wa, input logic [7:0] wd);
    int n_rst;
    int n;
    @(negedge CLK);
    START = 1'b1;
    if (wr_start) begin
      WE = 1'b1; WADDR = wa; WDATA = wd;
      if (wa < 6'd40) exp_mem[wa] = wd;
    end
    @(negedge CLK);
    START = 1'b0; WE = 1'b0;
    check_eq("crst_high", CORE_RST, 1);
    check_eq("busy_crst", BUSY, 1);
    check_eq("toerr_clr", TO_ERR, 0);
    n_rst = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      WE = 1'b0; START = 1'b0; DONE = 1'b0;
      if (CORE_RST) n_rst++;
      check_eq($sformatf("x_pt%0d", k), X, exp_mem[k][3:0]);
      check_eq($sformatf("y_pt%0d", k), Y, exp_mem[k][7:4]);
      if (inject && k == 2) begin
        WE = 1'b1; WADDR = 6'd5; WDATA = 8'hFF; START = 1'b1; DONE = 1'b1;
      end
    end
    check_eq("crst_len", n_rst, 0);
    @(negedge CLK);
    check_eq("xy_wait", {Y, X}, 0);
    check_eq("busy_wait", BUSY, 1);
    n = 0;
    if (give_done) begin
      repeat (2) @(negedge CLK);
      DONE = 1'b1; C1X = c1x; C1Y = c1y; C2X = c2x; C2Y = c2y;
      @(negedge CLK);
      DONE = 1'b0;
      while (!RES_VALID && n < 80) begin
        @(negedge CLK);
        n++;
      end
      check_eq("res_valid", RES_VALID, 1);
      check_eq("score", SCORE, exp_score);
      check_eq("r_c1", {R_C1Y, R_C1X}, {c1y, c1x});
      check_eq("r_c2", {R_C2Y, R_C2X}, {c2y, c2x});
      check_eq("toerr_ok", TO_ERR, 0);
    end else begin
      while (!RES_VALID && n < 300) begin
        @(negedge CLK);
        n++;
      end
      check_eq("to_latency", n, 100);
      check_eq("to_err", TO_ERR, 1);
      check_eq("to_score", SCORE, 0);
    end
    @(negedge CLK);
    check_eq("pulse_len", RES_VALID, 0);
    check_eq("busy_done", BUSY, 0);
    check_eq("score_hold", SCORE, exp_score);
    if (!give_done) check_eq("toerr_sticky", TO_ERR, 1);
  endtask

  initial begin
    #12;
    check_eq("rst_busy", BUSY, 0);
    check_eq("rst_corerst", CORE_RST, 1);
    check_eq("rst_xy", {Y, X}, 0);
    check_eq("rst_score", SCORE, 0);
    check_eq("rst_resvld", RES_VALID, 0);
    check_eq("rst_toerr", TO_ERR, 0);
    check_eq("rst_rc", {R_C1X, R_C1Y, R_C2X, R_C2Y}, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check_eq("idle_corerst", CORE_RST, 0);

    // Basic: all (3,3), centres on the cluster.
    for (int i = 0; i < 40; i++) write_pt(6'(i), 4'd3, 4'd3);
    run(4'd3, 4'd3, 4'd3, 4'd3, 1'b1, 40, 1'b0, 1'b0, 6'd0, 8'd0);

    // Split clusters.
    for (int i = 0; i < 40; i++)
      write_pt(6'(i), (i < 20) ? 4'd0 : 4'd15, (i < 20) ? 4'd0 : 4'd15);
    run(4'd0, 4'd0, 4'd15, 4'd15, 1'b1, 40, 1'b0, 1'b0, 6'd0, 8'd0);
    run(4'd0, 4'd0, 4'd8, 4'd8, 1'b1, 20, 1'b0, 1'b0, 6'd0, 8'd0);

    // Radius boundary; out-of-range writes must not alias; point1 written with START.
    write_pt(6'd0, 4'd4, 4'd0);
    for (int i = 1; i < 40; i++) write_pt(6'(i), 4'd15, 4'd15);
    write_pt(6'd40, 4'd0, 4'd0);
    write_pt(6'd63, 4'd0, 4'd0);
    run(4'd0, 4'd0, 4'd15, 4'd15, 1'b1, 39, 1'b0, 1'b1, 6'd1, 8'h33);

    // Overlap, with write/START/DONE injected while busy.
    for (int i = 0; i < 40; i++) write_pt(6'(i), 4'd5, 4'd5);
    run(4'd4, 4'd4, 4'd6, 4'd6, 1'b1, 40, 1'b1, 1'b0, 6'd0, 8'd0);

    // Timeout, then a normal run that must clear TO_ERR.
    run(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 0, 1'b0, 1'b0, 6'd0, 8'd0);
    run(4'd5, 4'd5, 4'd15, 4'd15, 1'b1, 40, 1'b0, 1'b0, 6'd0, 8'd0);

    // Reset mid-stream.
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (10) @(negedge CLK);
    check_eq("pre_rst_x", X, 5);
    RST_N = 1'b0;
    #1;
    check_eq("mid_rst_busy", BUSY, 0);
    check_eq("mid_rst_corerst", CORE_RST, 1);
    check_eq("mid_rst_xy", {Y, X}, 0);
    check_eq("mid_rst_score", SCORE, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check_eq("post_rst_corerst", CORE_RST, 0);
    check_eq("post_rst_busy", BUSY, 0);
    check_eq("post_rst_toerr", TO_ERR, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/laser_feeder.md
Name: laser_feeder

Overview:
- Host-side initiator for the LASER circle-placement core.
- Holds one 40-point pattern written by the host.
- Resets the core and streams the 40 points on X/Y with the exact cycle timing the core samples, then waits for DONE.
- Captures C1/C2 and scores them by counting stored points inside the union of the two radius-4 circles. This is the figure of merit for the core's answer.

Parameters:
- NPTS, 40, points per pattern. The core fixes this at 40; the bench never overrides it.
- TO_W, 16, width of the DONE-wait timeout counter.
- TO_MAX, 40000, cycles to wait for DONE before flagging timeout.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- WE  in  1  host pattern write strobe.
- WADDR  in  6  pattern index, 0..39. Values 40..63 are ignored.
- WDATA  in  8  {y[3:0], x[3:0]}.
- START  in  1  one-cycle request to run the stored pattern.
- BUSY  out  1  high from the START accept through RES_VALID.
- CORE_RST  out  1  synchronous active-high reset to the core.
- X  out  4  point x to the core.
- Y  out  4  point y to the core.
- DONE  in  1  core completion pulse.
- C1X, C1Y, C2X, C2Y  in  4 each  core result centres.
- R_C1X, R_C1Y, R_C2X, R_C2Y  out  4 each  latched centres.
- SCORE  out  6  covered-point count, 0..40.
- RES_VALID  out  1  one-cycle pulse when SCORE and R_* are valid.
- TO_ERR  out  1  sticky timeout flag. Cleared by the next accepted START.

Behaviour:
- Reset (RST_N=0, async): state IDLE. All outputs 0, except CORE_RST=1 (the core is held in reset). Pattern memory is not cleared.
- Memory writes:
  - Accepted only in IDLE; ignored while BUSY.
  - A WADDR>=40 write is dropped.
  - A write and START in the same cycle: the write lands first, and the stream uses the new data.
- States: IDLE -> CRST -> STREAM -> WAIT -> SCORE -> REPORT -> IDLE.
- IDLE:
  - CORE_RST=0, X=Y=0, BUSY=0.
  - START=1 -> CRST; clears TO_ERR. START while BUSY is ignored.
- CRST: exactly one cycle with CORE_RST=1. Call this cycle T.
- STREAM:
  - Point k is driven on {Y,X} during cycle T+1+k, for k=0..39. The core samples point 0 in its IDLE cycle and points 1..39 in IN_DATA.
  - Index counter runs 0..39; memory read is combinational or pre-fetched so there is no bubble.
  - After k=39 -> WAIT; X=Y=0 from then on.
- WAIT:
  - Timeout counter increments each cycle.
  - DONE=1 -> latch C1X..C2Y into R_* and -> SCORE.
  - Counter reaching TO_MAX without DONE -> TO_ERR=1, SCORE output forced to 0, -> REPORT.
  - DONE arriving outside WAIT is ignored.
- SCORE:
  - One point per cycle, 40 cycles.
  - For point p against centre c: dx=|px-cx|, dy=|py-cy| (4-bit); d2=dx*dx+dy*dy (9-bit).
  - A point is inside if d2<=16. The boundary is inclusive.
  - The accumulator adds 1 if the point is inside circle 1 OR circle 2. A point inside both counts once.
- REPORT:
  - RES_VALID=1 for one cycle. SCORE and R_* hold until the next START is accepted.
  - -> IDLE, BUSY=0 on the following cycle.
- Reset mid-operation: immediate return to IDLE. The sticky flag and score are cleared. CORE_RST=1 while RST_N=0.

Test Plan:
- Basic run: write all 40 points = (3,3); START.
  - Required: CORE_RST high exactly 1 cycle; X/Y=3/3 in cycles T+1..T+40.
  - Bench core model returns C1=C2=(3,3) -> SCORE=40, RES_VALID one pulse.
- Split clusters: points 0..19=(0,0), 20..39=(15,15).
  - C1=(0,0), C2=(15,15) -> SCORE=40.
  - C1=(0,0), C2=(8,8) -> SCORE=20.
- Radius boundary: point0=(4,0), point1=(3,3), the other 38 points=(15,15); C1=(0,0), C2=(15,15).
  - Point0 counts (d2=16); point1 does not (d2=18) -> SCORE=39.
- Overlap: all points=(5,5); C1=(4,4), C2=(6,6) -> SCORE=40, not 80.
- Timeout: model never raises DONE; TO_MAX=100 via override.
  - Required: TO_ERR=1, SCORE=0, RES_VALID pulse at WAIT entry+100.
  - The next START clears TO_ERR.
- Busy/reset protection:
  - A WE to index 5 during STREAM leaves memory unchanged.
  - A second START while BUSY is ignored.
  - RST_N low mid-STREAM -> BUSY=0, CORE_RST=1, X=Y=0 immediately.
